// File: rtl/q_value_argmax.sv
// Greedy-action selector: scans a serial stream of binary32 Q-values and reports
// the index and value of the largest one, skipping NaNs and breaking ties toward the lower index.
module q_value_argmax #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUMBER_OF_ACTIONS = 4,
    parameter int INDEX_WIDTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_valid,
    output logic [INDEX_WIDTH-1:0] o_action,
    output logic [DATA_WIDTH-1:0]  o_q_value,
    output logic                   o_nan,
    output logic                   o_busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam int                   LAST_INT   = NUMBER_OF_ACTIONS - 1;
    localparam logic [INDEX_WIDTH:0] LAST_COUNT = LAST_INT[INDEX_WIDTH:0];
    localparam logic [DATA_WIDTH-1:0] CANON_NAN = 32'h7FC00000;

    // Maps a non-NaN float onto an unsigned key whose order matches numeric order;
    // -0 is folded onto +0 first so the two compare equal.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] c;
        c = (x == 32'h80000000) ? '0 : x;
        order_key = c[DATA_WIDTH-1] ? ~c : (c | 32'h80000000);
    endfunction

    logic [0:0]             state;
    logic [INDEX_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0]  max_key;
    logic [DATA_WIDTH-1:0]  max_data;
    logic [INDEX_WIDTH-1:0] max_idx;
    logic                   have_max;
    logic                   nan_flag;

    logic                   fresh;
    logic                   cur_have;
    logic                   cur_nan;
    logic                   in_nan;
    logic [DATA_WIDTH-1:0]  in_key;
    logic                   take;
    logic                   is_last;
    logic [DATA_WIDTH-1:0]  next_key;
    logic [DATA_WIDTH-1:0]  next_data;
    logic [INDEX_WIDTH-1:0] next_idx;
    logic                   next_have;
    logic                   next_nan;

    // The first value of an evaluation ignores whatever the previous one left behind.
    always_comb begin
        fresh     = (count == '0);
        cur_have  = fresh ? 1'b0 : have_max;
        cur_nan   = fresh ? 1'b0 : nan_flag;
        in_nan    = (&i_data[30:23]) && (|i_data[22:0]);
        in_key    = order_key(i_data);
        take      = !in_nan && (!cur_have || (in_key > max_key));
        is_last   = (count == LAST_COUNT);
        next_key  = take ? in_key : max_key;
        next_data = take ? i_data : max_data;
        next_idx  = take ? count[INDEX_WIDTH-1:0] : max_idx;
        next_have = cur_have || take;
        next_nan  = cur_nan || in_nan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            max_key  <= '0;
            max_data <= '0;
            max_idx  <= '0;
            have_max <= 1'b0;
            nan_flag <= 1'b0;
        end else if (i_valid) begin
            state    <= is_last ? IDLE : SCAN;
            count    <= is_last ? '0 : count + 1'b1;
            max_key  <= next_key;
            max_data <= next_data;
            max_idx  <= next_idx;
            have_max <= next_have;
            nan_flag <= next_nan;
        end
    end

    // Result registers hold until the next evaluation completes; an all-NaN
    // evaluation reports action 0 with the canonical quiet NaN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_action  <= '0;
            o_q_value <= '0;
            o_nan     <= 1'b0;
        end else begin
            o_valid <= i_valid && is_last;
            if (i_valid && is_last) begin
                o_action  <= next_have ? next_idx : '0;
                o_q_value <= next_have ? next_data : CANON_NAN;
                o_nan     <= next_nan;
            end
        end
    end

    assign o_busy = (state == SCAN);

endmodule
